// File: rtl/pulse_sync_f2s_mc_if.sv
// pulse_sync_f2s_mc_if: per-channel event, clear, delivered-pulse and status bundle
interface pulse_sync_f2s_mc_if #(
  parameter int CH = 4
);
  logic [CH-1:0] pulse_fast;
  logic [CH-1:0] ovf_clr;
  logic [CH-1:0] pulse_slow;
  logic [CH-1:0] busy;
  logic [CH-1:0] ovf;
  modport master (output pulse_fast, ovf_clr, input pulse_slow, busy, ovf);
  modport slave (input pulse_fast, ovf_clr, output pulse_slow, busy, ovf);
endinterface

// File: rtl/pulse_sync_f2s_mc.sv
// pulse_sync_f2s_mc: per-channel fast-to-slow pulse synchroniser with queued replay
module pulse_sync_f2s_mc #(
  parameter int CH = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = 3
) (
  input logic clk_fast,
  input logic clk_slow,
  input logic rstn,
  pulse_sync_f2s_mc_if.slave sync_if
);
  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CH-1:0] busy_v, ovf_v, pulse_slow_v;
  for (genvar c = 0; c < CH; c++) begin : g_ch
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic req_q, req_d, busy_q, busy_d, ovf_q, ovf_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, req_sync_q;
    logic req_dly_q, pulse_slow_q;
    logic pulse, ack_f, req_s, launch, drop;
    assign pulse = sync_if.pulse_fast[c];
    assign ack_f = ack_sync_q[SYNC_STAGES-1];
    assign req_s = req_sync_q[SYNC_STAGES-1];
    assign launch = state_q == IDLE && (pulse || cnt_q != '0);
    // a pulse that cannot be queued or launched is lost and flagged
    assign drop = pulse && !launch && cnt_q == CNT_MAX;
    always_comb begin
      state_d = launch ? REQ
              : (state_q == REQ && ack_f) ? RELEASE
              : (state_q == RELEASE && !ack_f) ? IDLE
              : state_q;
      cnt_d = (pulse && !launch) ? (drop ? cnt_q : cnt_q + 1'b1)
            : (launch && !pulse) ? cnt_q - 1'b1
            : cnt_q;
      ovf_d = drop | (ovf_q & ~sync_if.ovf_clr[c]);
      req_d = state_d == REQ;
      busy_d = state_d != IDLE || cnt_d != '0;
    end
    always_ff @(posedge clk_fast or negedge rstn) begin
      if (!rstn) begin
        state_q <= IDLE;
        cnt_q <= '0;
        req_q <= 1'b0;
        busy_q <= 1'b0;
        ovf_q <= 1'b0;
        ack_sync_q <= '0;
      end else begin
        state_q <= state_d;
        cnt_q <= cnt_d;
        req_q <= req_d;
        busy_q <= busy_d;
        ovf_q <= ovf_d;
        ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], req_s};
      end
    end
    // the last req synchroniser stage doubles as the ack level returned to clk_fast
    always_ff @(posedge clk_slow or negedge rstn) begin
      if (!rstn) begin
        req_sync_q <= '0;
        req_dly_q <= 1'b0;
        pulse_slow_q <= 1'b0;
      end else begin
        req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_q};
        req_dly_q <= req_s;
        pulse_slow_q <= req_s & ~req_dly_q;
      end
    end
    assign busy_v[c] = busy_q;
    assign ovf_v[c] = ovf_q;
    assign pulse_slow_v[c] = pulse_slow_q;
  end
  assign sync_if.busy = busy_v;
  assign sync_if.ovf = ovf_v;
  assign sync_if.pulse_slow = pulse_slow_v;
endmodule

// File: tb/tb_pulse_sync_f2s_mc.sv
// tb_pulse_sync_f2s_mc: directed checks of pulse delivery, queuing, overflow and reset
module tb_pulse_sync_f2s_mc;
  logic clk_fast = 1'b0;
  logic clk_slow = 1'b0;
  logic rstn = 1'b0;
  int checks = 0;
  int errors = 0;
  int sc [4] = '{0, 0, 0, 0};
  int wide = 0;
  logic [3:0] prev = '0;
  pulse_sync_f2s_mc_if #(.CH(4)) sif ();
  pulse_sync_f2s_mc #(.CH(4), .SYNC_STAGES(2), .CNT_W(3)) dut (
    .clk_fast(clk_fast),
    .clk_slow(clk_slow),
    .rstn(rstn),
    .sync_if(sif)
  );
  always #5 clk_fast = ~clk_fast;
  initial begin
    #3;
    forever #20 clk_slow = ~clk_slow;
  end
  always @(posedge clk_slow) begin
    for (int i = 0; i < 4; i++) begin
      if (sif.pulse_slow[i]) sc[i]++;
      if (sif.pulse_slow[i] && prev[i]) wide++;
    end
    prev <= sif.pulse_slow;
  end
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic pulse(input logic [3:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      sif.pulse_fast = m;
      @(negedge clk_fast);
    end
    sif.pulse_fast = '0;
  endtask
  task automatic wait_idle(input logic [3:0] m, input string tag);
    for (int k = 0; k < 3000 && (sif.busy & m) != '0; k++) @(negedge clk_fast);
    chk(tag, int'((sif.busy & m) == '0), 1);
  endtask
  initial begin
    int b [4];
    int n;
    logic [3:0] pat [8];
    pat = '{4'hF, 4'h5, 4'h0, 4'hA, 4'h3, 4'h8, 4'h8, 4'h1};
    sif.pulse_fast = '0;
    sif.ovf_clr = '0;
    repeat (4) @(negedge clk_fast);
    chk("rst_pulse_slow", int'(sif.pulse_slow), 0);
    chk("rst_busy", int'(sif.busy), 0);
    chk("rst_ovf", int'(sif.ovf), 0);
    rstn = 1'b1;
    repeat (3) @(negedge clk_fast);
    // single pulse on channel 0
    b = sc;
    pulse(4'b0001, 1);
    chk("single_busy", int'(sif.busy), 1);
    for (n = 1; n <= 8; n++) begin
      @(posedge clk_slow);
      #1;
      if (sif.pulse_slow[0]) break;
    end
    chk("single_latency", int'(n >= 3 && n <= 4), 1);
    chk("single_others_quiet", int'(sif.pulse_slow[3:1]), 0);
    @(negedge clk_fast);
    wait_idle(4'b0001, "single_idle");
    chk("single_count0", sc[0] - b[0], 1);
    chk("single_count_others", (sc[1] - b[1]) + (sc[2] - b[2]) + (sc[3] - b[3]), 0);
    // five back-to-back pulses on channel 1
    b = sc;
    for (int i = 0; i < 5; i++) begin
      sif.pulse_fast = 4'b0010;
      @(negedge clk_fast);
      chk("b2b_busy", int'(sif.busy[1]), 1);
    end
    sif.pulse_fast = '0;
    wait_idle(4'b0010, "b2b_idle");
    chk("b2b_count", sc[1] - b[1], 5);
    chk("b2b_ovf", int'(sif.ovf[1]), 0);
    // saturation on channel 2: 1 in flight + 7 queued, 4 dropped
    b = sc;
    pulse(4'b0100, 12);
    chk("sat_ovf_set", int'(sif.ovf), 4);
    wait_idle(4'b0100, "sat_idle");
    chk("sat_count", sc[2] - b[2], 8);
    chk("sat_ovf_sticky", int'(sif.ovf), 4);
    sif.ovf_clr = 4'b0100;
    @(negedge clk_fast);
    sif.ovf_clr = '0;
    chk("ovf_clr", int'(sif.ovf), 0);
    b = sc;
    for (int i = 0; i < 9; i++) begin
      sif.pulse_fast = 4'b0100;
      sif.ovf_clr = (i == 8) ? 4'b0100 : 4'b0000;
      @(negedge clk_fast);
    end
    sif.pulse_fast = '0;
    sif.ovf_clr = '0;
    chk("ovf_set_wins", int'(sif.ovf), 4);
    sif.ovf_clr = 4'b0100;
    @(negedge clk_fast);
    sif.ovf_clr = '0;
    wait_idle(4'b0100, "sat2_idle");
    chk("sat2_count", sc[2] - b[2], 8);
    chk("sat2_ovf", int'(sif.ovf), 0);
    // concurrent pattern on all channels, none saturating
    b = sc;
    for (int i = 0; i < 8; i++) begin
      sif.pulse_fast = pat[i];
      @(negedge clk_fast);
    end
    sif.pulse_fast = '0;
    wait_idle(4'b1111, "multi_idle");
    chk("multi_ch0", sc[0] - b[0], 4);
    chk("multi_ch1", sc[1] - b[1], 3);
    chk("multi_ch2", sc[2] - b[2], 2);
    chk("multi_ch3", sc[3] - b[3], 4);
    chk("multi_ovf", int'(sif.ovf), 0);
    // pulse coincident with relaunch from IDLE while cnt=3
    b = sc;
    pulse(4'b1000, 4);
    for (int k = 0; k < 500 && dut.g_ch[3].state_q != 2'd0; k++) @(negedge clk_fast);
    chk("relaunch_at_idle", int'(dut.g_ch[3].state_q == 2'd0), 1);
    pulse(4'b1000, 1);
    chk("relaunch_cnt", int'(dut.g_ch[3].cnt_q), 3);
    chk("relaunch_busy", int'(sif.busy[3]), 1);
    wait_idle(4'b1000, "relaunch_idle");
    chk("relaunch_count", sc[3] - b[3], 5);
    // reset while channel 3 is in REQ with cnt=2
    pulse(4'b1000, 3);
    chk("pre_rst_cnt", int'(dut.g_ch[3].cnt_q), 2);
    b = sc;
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", int'(sif.busy), 0);
    chk("mid_rst_ovf", int'(sif.ovf), 0);
    chk("mid_rst_pulse_slow", int'(sif.pulse_slow), 0);
    repeat (3) @(negedge clk_fast);
    rstn = 1'b1;
    repeat (20) @(posedge clk_slow);
    #1;
    chk("post_rst_no_pulse", sc[3] - b[3], 0);
    chk("post_rst_busy", int'(sif.busy), 0);
    chk("pulse_width", wide, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
